// File: rtl/servant_sample_pacer.sv
// rtl/servant_sample_pacer.sv - paced sample FIFO feeding ESTU encoding-slot strobes
// Optional SAMPLE_PACER_STATS_EN adds DROPS (reg 3) and RELEASED (reg 4) counters.
module servant_sample_pacer #(
   parameter int DEPTH      = 16,
   parameter int DATA_W     = 16,
   parameter int PERIOD_W   = 16,
   parameter int PERIOD_RST = 24000
) (
   input  logic              i_wb_clk,
   input  logic              i_wb_rst_n,
   input  logic [31:0]       i_wb_adr,
   input  logic [31:0]       i_wb_dat,
   input  logic              i_wb_we,
   input  logic              i_wb_cyc,
   output logic [31:0]       o_wb_rdt,
   output logic              o_wb_ack,
   input  logic              i_wen_sample,
   input  logic [DATA_W-1:0] i_wr_data_sample,
   output logic              o_en_encoding_slot,
   output logic [DATA_W-1:0] o_sample
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic                ack_q, ack_d;
   logic [31:0]         rdt_q, rdt_d;
   logic                enable_q, enable_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                strobe_q, strobe_d;
   logic [DATA_W-1:0]   sample_q, sample_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
`ifdef SAMPLE_PACER_STATS_EN
   logic [15:0]         drops_q, drops_d;
   logic [31:0]         released_q, released_d;
`endif

   logic       wb_access, wb_wr, flush, full, empty, pop, push, ovf_set;
   logic [2:0] reg_sel;
   logic [31:0] rd_data;
   logic       unused_bits;

   assign unused_bits = ^{i_wb_adr[31:5], i_wb_adr[1:0], i_wb_dat};

   always_comb begin
      reg_sel   = i_wb_adr[4:2];
      wb_access = i_wb_cyc & ~ack_q;
      wb_wr     = wb_access & i_wb_we;
      flush     = wb_wr & (reg_sel == 3'd0) & i_wb_dat[1];
      full      = (count_q == CNT_W'(DEPTH));
      empty     = (count_q == '0);
      // Flush wins over a same-cycle pop or push so nothing leaks past it.
      pop       = enable_q & (cnt_q == '0) & ~empty & ~flush;
      push      = i_wen_sample & (~full | pop) & ~flush;
      ovf_set   = i_wen_sample & full & ~pop & ~flush;
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         3'd0: rd_data[0] = enable_q;
         3'd1: rd_data = 32'(period_q);
         3'd2: begin
            rd_data[CNT_W-1:0] = count_q;
            rd_data[8]         = empty;
            rd_data[9]         = full;
            rd_data[10]        = ovf_q;
         end
`ifdef SAMPLE_PACER_STATS_EN
         3'd3: rd_data = 32'(drops_q);
         3'd4: rd_data = released_q;
`endif
         default: rd_data = '0;
      endcase
   end

   always_comb begin
      ack_d    = i_wb_cyc & ~ack_q;
      rdt_d    = wb_access ? rd_data : rdt_q;
      enable_d = (wb_wr && reg_sel == 3'd0) ? i_wb_dat[0] : enable_q;
      period_d = (wb_wr && reg_sel == 3'd1) ? i_wb_dat[PERIOD_W-1:0] : period_q;
      ovf_d    = (ovf_q & ~(wb_wr && reg_sel == 3'd2 && i_wb_dat[10])) | ovf_set;

      // Disabled or flushed: hold at PERIOD; on pop reload max(PERIOD,1)-1.
      if (!enable_q || flush)
         cnt_d = period_q;
      else if (pop)
         cnt_d = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
      else if (cnt_q != '0)
         cnt_d = cnt_q - PERIOD_W'(1);
      else
         cnt_d = cnt_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_ptr_d = wr_ptr_q + PTR_W'(push);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      strobe_d = pop;
      sample_d = pop ? mem_q[rd_ptr_q] : sample_q;

`ifdef SAMPLE_PACER_STATS_EN
      if (wb_wr && reg_sel == 3'd3)
         drops_d = '0;
      else if (ovf_set && drops_q != 16'hFFFF)
         drops_d = drops_q + 16'd1;
      else
         drops_d = drops_q;
      if (wb_wr && reg_sel == 3'd4)
         released_d = '0;
      else
         released_d = released_q + 32'(pop);
`endif
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         ack_q      <= 1'b0;
         rdt_q      <= '0;
         enable_q   <= 1'b0;
         period_q   <= PERIOD_W'(PERIOD_RST);
         cnt_q      <= PERIOD_W'(PERIOD_RST);
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         strobe_q   <= 1'b0;
         sample_q   <= '0;
`ifdef SAMPLE_PACER_STATS_EN
         drops_q    <= '0;
         released_q <= '0;
`endif
      end else begin
         ack_q      <= ack_d;
         rdt_q      <= rdt_d;
         enable_q   <= enable_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         strobe_q   <= strobe_d;
         sample_q   <= sample_d;
`ifdef SAMPLE_PACER_STATS_EN
         drops_q    <= drops_d;
         released_q <= released_d;
`endif
      end
   end

   // Storage needs no reset; count_q alone defines which entries are live.
   always_ff @(posedge i_wb_clk) begin
      if (push)
         mem_q[wr_ptr_q] <= i_wr_data_sample;
   end

   assign o_wb_ack           = ack_q;
   assign o_wb_rdt           = rdt_q;
   assign o_en_encoding_slot = strobe_q;
   assign o_sample           = sample_q;
endmodule

// File: tb/tb_servant_sample_pacer.sv
// tb/tb_servant_sample_pacer.sv - scoreboard bench for servant_sample_pacer
module tb_servant_sample_pacer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] i_wb_adr = '0;
   logic [31:0] i_wb_dat = '0;
   logic        i_wb_we = 1'b0;
   logic        i_wb_cyc = 1'b0;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;
   logic        i_wen_sample = 1'b0;
   logic [15:0] i_wr_data_sample = '0;
   logic        o_en_encoding_slot;
   logic [15:0] o_sample;

   servant_sample_pacer dut (
      .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
      .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
      .i_wen_sample(i_wen_sample), .i_wr_data_sample(i_wr_data_sample),
      .o_en_encoding_slot(o_en_encoding_slot), .o_sample(o_sample)
   );

   always #5 clk = ~clk;

   typedef struct {logic [15:0] data; int cyc;} strobe_t;
   typedef struct {bit chk; logic [31:0] exp; string nm;} rd_t;

   strobe_t exp_q[$];
   rd_t     rd_q[$];
   int      tests = 0;
   int      fails = 0;
   int      cyc_n = 0;
   strobe_t se;
   rd_t     re;

   always @(posedge clk) cyc_n = cyc_n + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (o_en_encoding_slot) begin
            if (exp_q.size() == 0) begin
               tests = tests + 1;
               fails = fails + 1;
               $display("FAIL unexpected_strobe: got sample 0x%0h expected no strobe (cycle %0d)", o_sample, cyc_n);
            end else begin
               se = exp_q.pop_front();
               check("strobe_data", 32'(o_sample), 32'(se.data));
               if (se.cyc >= 0) check("strobe_cycle", 32'(cyc_n), 32'(se.cyc));
            end
         end
         if (o_wb_ack) begin
            if (rd_q.size() == 0) begin
               tests = tests + 1;
               fails = fails + 1;
               $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc_n);
            end else begin
               re = rd_q.pop_front();
               if (re.chk) check(re.nm, o_wb_rdt, re.exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wb_xfer(input bit we, input logic [2:0] r, input logic [31:0] d,
                          input logic [31:0] exp, input string nm);
      rd_t it;
      it.chk = ~we;
      it.exp = exp;
      it.nm  = nm;
      rd_q.push_back(it);
      i_wb_cyc = 1'b1;
      i_wb_we  = we;
      i_wb_adr = {27'b0, r, 2'b00};
      i_wb_dat = d;
      check({nm, "_ack_pre"}, 32'(o_wb_ack), 32'd0);
      tick(1);
      check({nm, "_ack"}, 32'(o_wb_ack), 32'd1);
      i_wb_cyc = 1'b0;
      i_wb_we  = 1'b0;
      tick(1);
      check({nm, "_ack_post"}, 32'(o_wb_ack), 32'd0);
   endtask

   task automatic wb_write(input logic [2:0] r, input logic [31:0] d);
      wb_xfer(1'b1, r, d, 32'd0, "wr");
   endtask

   task automatic wb_read(input logic [2:0] r, input logic [31:0] exp, input string nm);
      wb_xfer(1'b0, r, 32'd0, exp, nm);
   endtask

   // off: expected strobe cycle relative to the push cycle, -1 means order only.
   task automatic push(input logic [15:0] d, input bit expect_pop, input int off);
      strobe_t s;
      if (expect_pop) begin
         s.data = d;
         s.cyc  = (off < 0) ? -1 : cyc_n + off;
         exp_q.push_back(s);
      end
      i_wen_sample     = 1'b1;
      i_wr_data_sample = d;
      tick(1);
      i_wen_sample     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_ack", 32'(o_wb_ack), 32'd0);
      check("rst_rdt", o_wb_rdt, 32'd0);
      check("rst_strobe", 32'(o_en_encoding_slot), 32'd0);
      check("rst_sample", 32'(o_sample), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      wb_read(3'd0, 32'h0, "rd_ctrl_rst");
      wb_read(3'd1, 32'h5DC0, "rd_period_rst");
      wb_read(3'd2, 32'h100, "rd_status_rst");
      wb_write(3'd7, 32'hFFFF_FFFF);
      wb_read(3'd7, 32'h0, "rd_unmapped");
      wb_read(3'd0, 32'h0, "rd_ctrl_after_unmapped");

      // Paced release at PERIOD=4
      wb_write(3'd1, 32'd4);
      wb_write(3'd0, 32'd1);
      tick(10);
      push(16'h1111, 1'b1, 2);
      push(16'h2222, 1'b1, 5);
      push(16'h3333, 1'b1, 8);
      tick(20);
      check("drain_p4", 32'(exp_q.size()), 32'd0);

      // Overflow while disabled
      wb_write(3'd0, 32'd0);
      for (int i = 0; i < 18; i++) push(16'h3000 + 16'(i), (i < 16), -1);
      wb_read(3'd2, 32'h610, "rd_status_full");
`ifdef SAMPLE_PACER_STATS_EN
      wb_read(3'd3, 32'd2, "rd_drops");
`else
      wb_read(3'd3, 32'd0, "rd_drops_absent");
`endif
      wb_write(3'd2, 32'h400);
      wb_read(3'd2, 32'h210, "rd_status_ovf_clr");

      // Full FIFO at PERIOD=0 with a push every cycle
      wb_write(3'd1, 32'd0);
      fork
         begin
            wb_write(3'd0, 32'd1);
            wb_read(3'd2, 32'h210, "rd_status_steady");
         end
         begin
            tick(1);
            for (int i = 0; i < 20; i++) push(16'h4000 + 16'(i), 1'b1, -1);
         end
      join
      tick(40);
      check("drain_p0", 32'(exp_q.size()), 32'd0);
      wb_read(3'd2, 32'h100, "rd_status_drained");
`ifdef SAMPLE_PACER_STATS_EN
      wb_read(3'd4, 32'd39, "rd_released");
`else
      wb_read(3'd4, 32'd0, "rd_released_absent");
`endif

      // Flush with a simultaneous push
      wb_write(3'd0, 32'd0);
      for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i), 1'b0, -1);
      fork
         wb_write(3'd0, 32'd3);
         push(16'hAAAA, 1'b0, -1);
      join
      tick(22);
      wb_read(3'd2, 32'h100, "rd_status_flushed");
      wb_read(3'd0, 32'h1, "rd_ctrl_flushed");

      // Reset during a strobe
      push(16'hB001, 1'b1, 2);
      push(16'hB002, 1'b1, 2);
      push(16'hB003, 1'b1, 2);
      @(negedge clk);
      #1;
      check("strobe_before_rst", 32'(o_en_encoding_slot), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_strobe", 32'(o_en_encoding_slot), 32'd0);
      check("rst_mid_sample", 32'(o_sample), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick(1);
      wb_read(3'd2, 32'h100, "rd_status_after_rst");
      wb_read(3'd0, 32'h0, "rd_ctrl_after_rst");
      wb_read(3'd1, 32'h5DC0, "rd_period_after_rst");
      tick(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
